// File: rtl/rv32i_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_exec_ctrl_pkg
// Description : Shared opcode, ALU-op and ALU-select encodings plus the decoded
//               control bundle for the RV32I decode/execute core.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_exec_ctrl_pkg;

  // Major opcodes, taken from inst[6:2]
  localparam logic [4:0] OPC_RTYPE  = 5'b01100;
  localparam logic [4:0] OPC_IALU   = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    SEL_ADD    = 4'b0000,
    SEL_SUB    = 4'b0001,
    SEL_AND    = 4'b0010,
    SEL_OR     = 4'b0011,
    SEL_XOR    = 4'b0100,
    SEL_SLL    = 4'b0101,
    SEL_SRL    = 4'b0110,
    SEL_SRA    = 4'b0111,
    SEL_SLT    = 4'b1000,
    SEL_SLTU   = 4'b1001,
    SEL_PASS_B = 4'b1010
  } alu_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    auipc;
    logic    jal;
    logic    jalr;
    logic    halt;
    alu_op_e alu_op;
  } ctrl_t;

  // Function-field decode shared by R-type and I-ALU. Only R-type honours
  // inst[30] for fn3=000 (ADDI has no subtract form); both honour it for 101.
  function automatic alu_sel_e fn3_to_sel(input logic [2:0] fn3,
                                          input logic       f7,
                                          input logic       is_rtype);
    alu_sel_e sel;
    case (fn3)
      3'b000:  sel = (is_rtype && f7) ? SEL_SUB : SEL_ADD;
      3'b001:  sel = SEL_SLL;
      3'b010:  sel = SEL_SLT;
      3'b011:  sel = SEL_SLTU;
      3'b100:  sel = SEL_XOR;
      3'b101:  sel = f7 ? SEL_SRA : SEL_SRL;
      3'b110:  sel = SEL_OR;
      default: sel = SEL_AND;
    endcase
    return sel;
  endfunction

endpackage : rv32i_exec_ctrl_pkg
`default_nettype wire

// File: rtl/rv32i_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_exec_ctrl_if
// Description : Instruction/operand inputs and control/ALU outputs of the
//               decode/execute core, bundled for connection to the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_exec_ctrl_if #(
  parameter int N = 32
);

  // Pipeline side -> core
  logic [31:0]  inst;
  logic [N-1:0] pc;
  logic [N-1:0] rs1_data;
  logic [N-1:0] rs2_data;
  logic [N-1:0] imm;

  // Core -> ID/EX register (combinational)
  logic         reg_write;
  logic         mem_to_reg;
  logic         branch;
  logic         mem_read;
  logic         mem_write;
  logic         alu_src;
  logic         auipc;
  logic         jal;
  logic         jalr;
  logic         halt;
  logic [1:0]   alu_op;
  logic [3:0]   alu_sel;

  // Core -> EX/MEM (registered)
  logic [N-1:0] alu_result;
  logic         zero_flag;
  logic         carry_flag;
  logic         overflow_flag;
  logic         sign_flag;
  logic         branch_taken;

  modport master (
    output inst, pc, rs1_data, rs2_data, imm,
    input  reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src,
           auipc, jal, jalr, halt, alu_op, alu_sel,
           alu_result, zero_flag, carry_flag, overflow_flag, sign_flag,
           branch_taken
  );

  modport slave (
    input  inst, pc, rs1_data, rs2_data, imm,
    output reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src,
           auipc, jal, jalr, halt, alu_op, alu_sel,
           alu_result, zero_flag, carry_flag, overflow_flag, sign_flag,
           branch_taken
  );

endinterface : rv32i_exec_ctrl_if
`default_nettype wire

// File: rtl/rv32i_alu.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_alu
// Description : Combinational RV32I ALU producing result and Z/C/V/S flags.
//               Carry and overflow are meaningful for ADD/SUB only.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_alu
  import rv32i_exec_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  wire logic [N-1:0] a_i,
  input  wire logic [N-1:0] b_i,
  input  alu_sel_e          sel_i,
  output logic [N-1:0]      result_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              overflow_o,
  output logic              sign_o
);

  logic         w_is_sub;
  logic [N-1:0] w_b_eff;
  logic [N:0]   w_sum;
  logic [4:0]   w_shamt;

  assign w_is_sub = (sel_i == SEL_SUB);
  assign w_shamt  = b_i[4:0];

  // Shared 33-bit adder: subtraction is A + ~B + 1 so carry means "no borrow"
  always_comb begin
    w_b_eff = w_is_sub ? ~b_i : b_i;
    w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {{N{1'b0}}, w_is_sub};
  end

  // Result select; carry/overflow forced low outside ADD/SUB
  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (sel_i)
      SEL_ADD, SEL_SUB: begin
        result_o   = w_sum[N-1:0];
        carry_o    = w_sum[N];
        overflow_o = (a_i[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != a_i[N-1]);
      end
      SEL_AND:    result_o = a_i & b_i;
      SEL_OR:     result_o = a_i | b_i;
      SEL_XOR:    result_o = a_i ^ b_i;
      SEL_SLL:    result_o = a_i << w_shamt;
      SEL_SRL:    result_o = a_i >> w_shamt;
      SEL_SRA:    result_o = $signed(a_i) >>> w_shamt;
      SEL_SLT:    result_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      SEL_SLTU:   result_o = {{(N-1){1'b0}}, (a_i < b_i)};
      SEL_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign sign_o = result_o[N-1];

endmodule : rv32i_alu
`default_nettype wire

// File: rtl/rv32i_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_exec_ctrl
// Description : RV32I decode + execute core. Control outputs are
//               combinational for the ID/EX register; ALU result, flags and
//               branch decision are registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_exec_ctrl
  import rv32i_exec_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rv32i_exec_ctrl_if.slave   bus
);

  logic [4:0]   w_opcode;
  logic [2:0]   w_fn3;
  logic         w_f7;
  ctrl_t        w_ctrl;
  alu_sel_e     w_alu_sel;
  logic [N-1:0] w_op_a;
  logic [N-1:0] w_op_b;
  logic [N-1:0] w_alu_res;
  logic         w_zero;
  logic         w_carry;
  logic         w_ovf;
  logic         w_sign;
  logic         w_cond;
  logic         w_unused_inst;

  logic [N-1:0] result_d,   result_q;
  logic         zero_d,     zero_q;
  logic         carry_d,    carry_q;
  logic         overflow_d, overflow_q;
  logic         sign_d,     sign_q;
  logic         taken_d,    taken_q;

  assign w_opcode      = bus.inst[6:2];
  assign w_fn3         = bus.inst[14:12];
  assign w_f7          = bus.inst[30];
  // Register indices are consumed elsewhere in the pipeline
  assign w_unused_inst = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7], bus.inst[1:0]};

  // Main decoder: every field defaults low, each opcode raises only its own
  always_comb begin
    w_ctrl = '0;
    case (w_opcode)
      OPC_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALUOP_RTYPE;
      end
      OPC_IALU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALUOP_ITYPE;
      end
      OPC_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALUOP_BRANCH;
      end
      OPC_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.auipc     = 1'b1;
      end
      OPC_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jal       = 1'b1;
      end
      OPC_JALR: begin
        // jal also set so writeback picks PC+4 for both jump kinds
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.jal       = 1'b1;
        w_ctrl.jalr      = 1'b1;
      end
      OPC_SYSTEM: w_ctrl.halt = 1'b1;
      default:    w_ctrl = '0;
    endcase
  end

  // ALU control: LUI is the only alu_op=00 instruction that bypasses the adder
  always_comb begin
    w_alu_sel = SEL_ADD;
    case (w_ctrl.alu_op)
      ALUOP_ADD:    w_alu_sel = (w_opcode == OPC_LUI) ? SEL_PASS_B : SEL_ADD;
      ALUOP_BRANCH: w_alu_sel = SEL_SUB;
      ALUOP_RTYPE:  w_alu_sel = fn3_to_sel(w_fn3, w_f7, 1'b1);
      default:      w_alu_sel = fn3_to_sel(w_fn3, w_f7, 1'b0);
    endcase
  end

  assign w_op_a = w_ctrl.auipc   ? bus.pc  : bus.rs1_data;
  assign w_op_b = w_ctrl.alu_src ? bus.imm : bus.rs2_data;

  rv32i_alu #(
    .N (N)
  ) u_alu (
    .a_i        (w_op_a),
    .b_i        (w_op_b),
    .sel_i      (w_alu_sel),
    .result_o   (w_alu_res),
    .zero_o     (w_zero),
    .carry_o    (w_carry),
    .overflow_o (w_ovf),
    .sign_o     (w_sign)
  );

  // Branch condition from the SUB flags computed this cycle
  always_comb begin
    w_cond = 1'b0;
    case (w_fn3)
      3'b000:  w_cond = w_zero;
      3'b001:  w_cond = ~w_zero;
      3'b100:  w_cond = (w_sign != w_ovf);
      3'b101:  w_cond = (w_sign == w_ovf);
      3'b110:  w_cond = ~w_carry;
      3'b111:  w_cond = w_carry;
      default: w_cond = 1'b0;
    endcase
  end

  // Next-state values for the output register stage
  always_comb begin
    result_d   = w_alu_res;
    zero_d     = w_zero;
    carry_d    = w_carry;
    overflow_d = w_ovf;
    sign_d     = w_sign;
    taken_d    = w_ctrl.branch & w_cond;
  end

  // Output register stage, cleared asynchronously while reset is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      sign_q     <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      sign_q     <= sign_d;
      taken_q    <= taken_d;
    end
  end

  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.branch        = w_ctrl.branch;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.alu_src       = w_ctrl.alu_src;
  assign bus.auipc         = w_ctrl.auipc;
  assign bus.jal           = w_ctrl.jal;
  assign bus.jalr          = w_ctrl.jalr;
  assign bus.halt          = w_ctrl.halt;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.alu_sel       = w_alu_sel;
  assign bus.alu_result    = result_q;
  assign bus.zero_flag     = zero_q;
  assign bus.carry_flag    = carry_q;
  assign bus.overflow_flag = overflow_q;
  assign bus.sign_flag     = sign_q;
  assign bus.branch_taken  = taken_q;

endmodule : rv32i_exec_ctrl
`default_nettype wire

// File: tb/tb_rv32i_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_exec_ctrl
// Description : Directed scoreboard bench for rv32i_exec_ctrl. Stimulus pushes
//               expected control vector, result, flags and branch decision;
//               a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_exec_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rv32i_exec_ctrl_if #(.N(32)) bus ();

  rv32i_exec_ctrl #(
    .N (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src,
  //         auipc, jal, jalr, halt, alu_op[1:0], alu_sel[3:0]}
  // flg  = {zero, carry, overflow, sign}
  typedef struct {
    string       name;
    logic [15:0] ctrl;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        bt;
  } exp_t;

  exp_t exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [15:0] ctrl_vec();
    return {bus.reg_write, bus.mem_to_reg, bus.branch, bus.mem_read,
            bus.mem_write, bus.alu_src, bus.auipc, bus.jal, bus.jalr,
            bus.halt, bus.alu_op, bus.alu_sel};
  endfunction

  function automatic logic [3:0] flag_vec();
    return {bus.zero_flag, bus.carry_flag, bus.overflow_flag, bus.sign_flag};
  endfunction

  task automatic issue(input string name, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [15:0] ctrl, input logic [31:0] res,
                       input logic [3:0] flg, input logic bt);
    exp_t e;
    @(posedge clk);
    #2;
    bus.inst     = inst;
    bus.pc       = pc;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    bus.imm      = imm;
    e.name = name; e.ctrl = ctrl; e.res = res; e.flg = flg; e.bt = bt;
    exp_q.push_back(e);
  endtask

  // Monitor: control vector checked mid-cycle, registered outputs after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, " ctrl"}, {16'h0, ctrl_vec()}, {16'h0, e.ctrl});
        @(posedge clk);
        #1;
        chk({e.name, " result"}, bus.alu_result, e.res);
        chk({e.name, " flags"}, {28'h0, flag_vec()}, {28'h0, e.flg});
        chk({e.name, " taken"}, {31'h0, bus.branch_taken}, {31'h0, e.bt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    bus.inst = 32'h0000_0013;
    bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus.alu_result, 32'h0);
    chk("reset flags", {28'h0, flag_vec()}, 32'h0);
    chk("reset taken", {31'h0, bus.branch_taken}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name      inst          pc          rs1           rs2          imm          ctrl     result        ZCVS     bt
    issue("ADD",    32'h00000033, 32'h0,      32'h5,        32'h7,       32'h0,       16'h8020, 32'h0000000C, 4'b0000, 1'b0);
    issue("ADDOVF", 32'h00000033, 32'h0,      32'h7FFFFFFF, 32'h1,       32'h0,       16'h8020, 32'h80000000, 4'b0011, 1'b0);
    issue("SUB",    32'h40000033, 32'h0,      32'h5,        32'h7,       32'h0,       16'h8021, 32'hFFFFFFFE, 4'b0001, 1'b0);
    issue("SLT",    32'h00002033, 32'h0,      32'hFFFFFFFF, 32'h1,       32'h0,       16'h8028, 32'h00000001, 4'b0000, 1'b0);
    issue("SLTU",   32'h00003033, 32'h0,      32'hFFFFFFFF, 32'h1,       32'h0,       16'h8029, 32'h00000000, 4'b1000, 1'b0);
    issue("XOR",    32'h00004033, 32'h0,      32'h0000F0F0, 32'h0000FF00, 32'h0,      16'h8024, 32'h00000FF0, 4'b0000, 1'b0);
    issue("BEQ",    32'h00000063, 32'h0,      32'h1234,     32'h1234,    32'h0,       16'h2011, 32'h00000000, 4'b1100, 1'b1);
    issue("BLT",    32'h00004063, 32'h0,      32'hFFFFFFFF, 32'h1,       32'h0,       16'h2011, 32'hFFFFFFFE, 4'b0101, 1'b1);
    issue("BLTU",   32'h00006063, 32'h0,      32'hFFFFFFFF, 32'h1,       32'h0,       16'h2011, 32'hFFFFFFFE, 4'b0101, 1'b0);
    issue("SRAI",   32'h40405013, 32'h0,      32'h80000000, 32'h0,       32'h00000404, 16'h8437, 32'hF8000000, 4'b0001, 1'b0);
    issue("ADDI30", 32'h40000013, 32'h0,      32'h1,        32'h0,       32'h00000400, 16'h8430, 32'h00000401, 4'b0000, 1'b0);
    issue("LUI",    32'hABCDE037, 32'h0,      32'h55,       32'h0,       32'hABCDE000, 16'h840A, 32'hABCDE000, 4'b0001, 1'b0);
    issue("AUIPC",  32'h00001017, 32'h100,    32'h999,      32'h0,       32'h00001000, 16'h8600, 32'h00001100, 4'b0000, 1'b0);
    issue("LOAD",   32'h00802083, 32'h0,      32'h1000,     32'h0,       32'h8,       16'hD400, 32'h00001008, 4'b0000, 1'b0);
    issue("STORE",  32'h00112423, 32'h0,      32'h2000,     32'h1,       32'h8,       16'h0C00, 32'h00002008, 4'b0000, 1'b0);
    issue("JAL",    32'h008000EF, 32'h0,      32'h3,        32'h4,       32'h8,       16'h8100, 32'h00000007, 4'b0000, 1'b0);
    issue("JALR",   32'h000080E7, 32'h0,      32'h100,      32'h0,       32'h4,       16'h8580, 32'h00000104, 4'b0000, 1'b0);
    issue("SYSTEM", 32'h00000073, 32'h0,      32'h1,        32'h2,       32'h0,       16'h0040, 32'h00000003, 4'b0000, 1'b0);
    issue("FENCE",  32'h0000000F, 32'h0,      32'h10,       32'h20,      32'h0,       16'h0000, 32'h00000030, 4'b0000, 1'b0);
    issue("RSTPRE", 32'h00000033, 32'h0,      32'h7FFFFFFF, 32'h1,       32'h0,       16'h8020, 32'h80000000, 4'b0011, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) chk("scoreboard drain", exp_q.size(), 32'h0);

    // Mid-cycle asynchronous reset with non-zero registered state
    @(negedge clk);
    #1;
    chk("pre-reset result", bus.alu_result, 32'h80000000);
    rst_n = 1'b0;
    #1;
    chk("async reset result", bus.alu_result, 32'h0);
    chk("async reset flags", {28'h0, flag_vec()}, 32'h0);
    chk("reset comb ctrl", {16'h0, ctrl_vec()}, 32'h8020);
    @(posedge clk);
    #1;
    chk("held reset result", bus.alu_result, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("resume result", bus.alu_result, 32'h80000000);
    chk("resume flags", {28'h0, flag_vec()}, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rv32i_exec_ctrl
`default_nettype wire
